shift_unit_mc: RTL and testbench

- Multi-cycle, parametrised shift/rotate unit; successor to the fixed 32-bit left/right load-or-shift registers.
- Accepts an operand, an operation and a shift amount over a valid/ready handshake.
- Shifts STEP bits per cycle inside the datapath register and returns the result over a second valid/ready handshake.
- Serves as the shift execution unit of the CPU datapath where a full barrel shifter is too costly.

---
 rtl/shift_pkg.sv | 26 ++
 rtl/shift_step.sv | 33 +++
 rtl/shift_unit_mc.sv | 110 +++++++++++
 tb/tb_shift_unit_mc.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/shift_pkg.sv
// Shared types for the multi-cycle shift unit: operation encoding and FSM states.
package shift_pkg;

    typedef enum logic [2:0] {
        OpSll  = 3'd0,
        OpSrl  = 3'd1,
        OpSra  = 3'd2,
        OpRol  = 3'd3,
        OpRor  = 3'd4,
        OpPass = 3'd5
    } shift_op_t;

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StDone
    } state_t;

    localparam logic [2:0] OP_LAST_SHIFT = 3'd4;

    // Encodings above the last real shift (5-7) all pass the operand through.
    function automatic logic op_is_pass(input logic [2:0] op);
        return op > OP_LAST_SHIFT;
    endfunction

endpackage

// File: rtl/shift_step.sv
// Combinational single step: shifts or rotates data by n bits, where n never exceeds STEP.
module shift_step
    import shift_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned STEP  = 1
) (
    input  logic [WIDTH-1:0]         data,
    input  logic [2:0]               op,
    input  logic [$clog2(STEP):0]    n,
    output logic [WIDTH-1:0]         result
);

    logic [2*WIDTH-1:0] dbl;
    logic [2*WIDTH-1:0] rol_w;
    logic [2*WIDTH-1:0] ror_w;

    // Rotates shift a doubled copy so wrapped bits fall into the kept half.
    always_comb begin
        dbl   = {data, data};
        rol_w = dbl << n;
        ror_w = dbl >> n;
        case (op)
            OpSll:   result = data << n;
            OpSrl:   result = data >> n;
            OpSra:   result = $signed(data) >>> n;
            OpRol:   result = rol_w[2*WIDTH-1:WIDTH];
            OpRor:   result = ror_w[WIDTH-1:0];
            default: result = data;
        endcase
    end

endmodule

// File: rtl/shift_unit_mc.sv
// Multi-cycle shift/rotate unit: accepts a request, shifts up to STEP bits per cycle,
// then presents the registered result until the consumer takes it.
module shift_unit_mc
    import shift_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned AMT_W = $clog2(WIDTH),
    parameter int unsigned STEP  = 1
) (
    input  logic             clk,
    input  logic             r,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] din,
    input  logic [AMT_W-1:0] amt,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] dout,
    output logic             busy
);

    localparam int unsigned N_W = $clog2(STEP) + 1;

    if (WIDTH < 4 || (WIDTH & (WIDTH - 1)) != 0) begin : g_bad_width
        $fatal(1, "shift_unit_mc: WIDTH must be a power of two and at least 4");
    end
    if (STEP < 1 || STEP > WIDTH / 2 || (STEP & (STEP - 1)) != 0) begin : g_bad_step
        $fatal(1, "shift_unit_mc: STEP must be a power of two between 1 and WIDTH/2");
    end

    state_t           state_q;
    logic [WIDTH-1:0] data_q;
    logic [2:0]       op_q;
    logic [AMT_W-1:0] rem_q;
    logic [AMT_W-1:0] rem_next;
    logic [N_W-1:0]   step_n;
    logic [WIDTH-1:0] step_data;

    always_comb begin
        if (rem_q >= AMT_W'(STEP)) begin
            step_n = N_W'(STEP);
        end else begin
            step_n = rem_q[N_W-1:0];
        end
        rem_next = rem_q - AMT_W'(step_n);
    end

    shift_step #(
        .WIDTH (WIDTH),
        .STEP  (STEP)
    ) u_step (
        .data   (data_q),
        .op     (op_q),
        .n      (step_n),
        .result (step_data)
    );

    // Reset gates acceptance combinationally so nothing is taken while r is high.
    assign in_ready = (state_q == StIdle) && !r;

    always_ff @(posedge clk) begin
        if (r) begin
            state_q   <= StIdle;
            data_q    <= '0;
            op_q      <= '0;
            rem_q     <= '0;
            dout      <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (in_valid) begin
                        data_q <= din;
                        op_q   <= op;
                        busy   <= 1'b1;
                        if (op_is_pass(op) || amt == '0) begin
                            rem_q     <= '0;
                            dout      <= din;
                            out_valid <= 1'b1;
                            state_q   <= StDone;
                        end else begin
                            rem_q   <= amt;
                            state_q <= StShift;
                        end
                    end
                end
                StShift: begin
                    data_q <= step_data;
                    rem_q  <= rem_next;
                    if (rem_next == '0) begin
                        dout      <= step_data;
                        out_valid <= 1'b1;
                        state_q   <= StDone;
                    end
                end
                StDone: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        state_q   <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_shift_unit_mc.sv
// Bench for shift_unit_mc: unit 0 is STEP=1, unit 1 is STEP=4; results go through a queue.
module tb_shift_unit_mc;
    import shift_pkg::*;

    logic        clk;
    logic        r;
    logic        ivv   [2];
    logic        irv   [2];
    logic [2:0]  opv   [2];
    logic [31:0] dinv  [2];
    logic [4:0]  amtv  [2];
    logic        ovv   [2];
    logic        orv   [2];
    logic [31:0] doutv [2];
    logic        busyv [2];

    int          n_vec;
    int          n_bad;
    logic [31:0] exp_q[$];

    typedef struct {
        int          u;
        logic [2:0]  op;
        logic [31:0] din;
        logic [4:0]  amt;
        logic [31:0] exp;
    } vec_t;

    vec_t tbl[14];

    shift_unit_mc #(.WIDTH(32), .AMT_W(5), .STEP(1)) u_dut0 (
        .clk       (clk),
        .r         (r),
        .in_valid  (ivv[0]),
        .in_ready  (irv[0]),
        .op        (opv[0]),
        .din       (dinv[0]),
        .amt       (amtv[0]),
        .out_valid (ovv[0]),
        .out_ready (orv[0]),
        .dout      (doutv[0]),
        .busy      (busyv[0])
    );

    shift_unit_mc #(.WIDTH(32), .AMT_W(5), .STEP(4)) u_dut1 (
        .clk       (clk),
        .r         (r),
        .in_valid  (ivv[1]),
        .in_ready  (irv[1]),
        .op        (opv[1]),
        .din       (dinv[1]),
        .amt       (amtv[1]),
        .out_valid (ovv[1]),
        .out_ready (orv[1]),
        .dout      (doutv[1]),
        .busy      (busyv[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Pops the oldest expected result and compares it with the presented dout.
    task automatic sb_check(input int u, input string nm);
        logic [31:0] e;
        if (exp_q.size() == 0) begin
            chk({nm, " queue"}, 32'd1, 32'd0);
        end else begin
            e = exp_q.pop_front();
            chk({nm, " dout"}, doutv[u], e);
        end
    endtask

    // Full transaction; caller is 1 time unit after a posedge with the unit idle.
    task automatic do_op(input int u, input logic [2:0] o, input logic [31:0] d,
                         input logic [4:0] a, input logic [31:0] exp, input string nm);
        int step;
        int lat;
        int edges;
        step = (u == 0) ? 1 : 4;
        lat  = (o > 3'd4 || a == 5'd0) ? 1 : 1 + (int'(a) + step - 1) / step;
        ivv[u]  = 1'b1;
        opv[u]  = o;
        dinv[u] = d;
        amtv[u] = a;
        orv[u]  = 1'b0;
        exp_q.push_back(exp);
        chk({nm, " in_ready"}, 32'(irv[u]), 32'd1);
        tick();
        ivv[u] = 1'b0;
        edges  = 1;
        while (!ovv[u] && edges < 200) begin
            tick();
            edges++;
        end
        chk({nm, " latency"}, 32'(edges), 32'(lat));
        sb_check(u, nm);
        chk({nm, " busy"}, 32'(busyv[u]), 32'd1);
        orv[u] = 1'b1;
        tick();
        orv[u] = 1'b0;
        chk({nm, " out_valid drop"}, 32'(ovv[u]), 32'd0);
        chk({nm, " dout hold"}, doutv[u], exp);
    endtask

    initial begin
        logic seen_valid;
        n_vec = 0;
        n_bad = 0;
        for (int i = 0; i < 2; i++) begin
            ivv[i]  = 1'b0;
            opv[i]  = 3'd0;
            dinv[i] = 32'd0;
            amtv[i] = 5'd0;
            orv[i]  = 1'b0;
        end

        tbl[0]  = '{0, OpSll, 32'h0000_0001, 5'd4,  32'h0000_0010};
        tbl[1]  = '{0, OpSra, 32'h8000_0000, 5'd31, 32'hFFFF_FFFF};
        tbl[2]  = '{0, OpSrl, 32'h8000_0000, 5'd31, 32'h0000_0001};
        tbl[3]  = '{0, OpRor, 32'h0000_00F1, 5'd4,  32'h1000_000F};
        tbl[4]  = '{0, OpRol, 32'h8000_0001, 5'd1,  32'h0000_0003};
        tbl[5]  = '{0, 3'd5,  32'h1234_5678, 5'd9,  32'h1234_5678};
        tbl[6]  = '{0, 3'd7,  32'hCAFE_F00D, 5'd31, 32'hCAFE_F00D};
        tbl[7]  = '{0, OpRol, 32'h1234_5678, 5'd8,  32'h3456_7812};
        tbl[8]  = '{0, OpSra, 32'h7FFF_0000, 5'd16, 32'h0000_7FFF};
        tbl[9]  = '{1, OpSrl, 32'hF000_0000, 5'd7,  32'h01E0_0000};
        tbl[10] = '{1, OpSll, 32'h0000_0001, 5'd5,  32'h0000_0020};
        tbl[11] = '{1, OpRol, 32'h8000_0001, 5'd9,  32'h0000_0300};
        tbl[12] = '{1, OpSra, 32'h8000_0000, 5'd31, 32'hFFFF_FFFF};
        tbl[13] = '{1, OpRor, 32'h1234_5678, 5'd31, 32'h2468_ACF0};

        // Power-on reset held for two cycles.
        r = 1'b1;
        tick();
        tick();
        chk("reset out_valid", 32'(ovv[0]), 32'd0);
        chk("reset dout", doutv[0], 32'd0);
        chk("reset busy", 32'(busyv[0]), 32'd0);
        chk("reset in_ready", 32'(irv[0]), 32'd0);
        r = 1'b0;
        tick();
        chk("release in_ready", 32'(irv[0]), 32'd1);

        for (int i = 0; i < 14; i++) begin
            do_op(tbl[i].u, tbl[i].op, tbl[i].din, tbl[i].amt, tbl[i].exp,
                  $sformatf("vec%0d", i));
        end

        // Reset while idle with a non-zero result held on dout.
        r = 1'b1;
        #1;
        chk("idle reset in_ready", 32'(irv[0]), 32'd0);
        tick();
        tick();
        chk("idle reset dout", doutv[0], 32'd0);
        chk("idle reset busy", 32'(busyv[0]), 32'd0);
        r = 1'b0;
        tick();
        chk("idle release in_ready", 32'(irv[0]), 32'd1);

        // amt=0 result stalled by the consumer while a new request waits.
        ivv[0]  = 1'b1;
        opv[0]  = OpSll;
        dinv[0] = 32'hDEAD_BEEF;
        amtv[0] = 5'd0;
        orv[0]  = 1'b0;
        exp_q.push_back(32'hDEAD_BEEF);
        tick();
        chk("amt0 out_valid", 32'(ovv[0]), 32'd1);
        dinv[0] = 32'h0000_0003;
        amtv[0] = 5'd2;
        for (int c = 0; c < 3; c++) begin
            chk($sformatf("stall%0d dout", c), doutv[0], 32'hDEAD_BEEF);
            chk($sformatf("stall%0d in_ready", c), 32'(irv[0]), 32'd0);
            chk($sformatf("stall%0d out_valid", c), 32'(ovv[0]), 32'd1);
            tick();
        end
        sb_check(0, "stall");
        orv[0] = 1'b1;
        tick();
        orv[0] = 1'b0;
        chk("handoff busy", 32'(busyv[0]), 32'd0);
        chk("handoff in_ready", 32'(irv[0]), 32'd1);
        chk("handoff dout", doutv[0], 32'hDEAD_BEEF);
        do_op(0, OpSll, 32'h0000_0003, 5'd2, 32'h0000_000C, "after_stall");

        // Reset during the fifth SHIFT cycle abandons the operation.
        ivv[0]  = 1'b1;
        opv[0]  = OpSll;
        dinv[0] = 32'h0000_0001;
        amtv[0] = 5'd20;
        tick();
        opv[0]  = OpSrl;
        dinv[0] = 32'h0000_0055;
        for (int c = 0; c < 4; c++) begin
            chk($sformatf("shift%0d in_ready", c), 32'(irv[0]), 32'd0);
            chk($sformatf("shift%0d busy", c), 32'(busyv[0]), 32'd1);
            tick();
        end
        r = 1'b1;
        tick();
        r      = 1'b0;
        ivv[0] = 1'b0;
        chk("abort busy", 32'(busyv[0]), 32'd0);
        chk("abort dout", doutv[0], 32'd0);
        seen_valid = 1'b0;
        for (int c = 0; c < 25; c++) begin
            if (ovv[0]) seen_valid = 1'b1;
            tick();
        end
        chk("abort no out_valid", 32'(seen_valid), 32'd0);
        do_op(0, OpSrl, 32'h0000_0080, 5'd7, 32'h0000_0001, "after_abort");

        chk("queue drained", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
